// File: rtl/fib_pkg.sv
// Shared constants, FSM state type and digit-count helper for the Fibonacci BCD stage.
package fib_pkg;

    localparam int FIB_IN_W       = 32;
    localparam int FIB_BCD_DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fib_bcd_state_t;

    // Smallest digit count d with 10^d >= 2^w, i.e. enough to hold any w-bit value.
    function automatic int fib_bcd_digits(input int w);
        longint unsigned lim;
        longint unsigned p;
        int              d;
        lim = 64'd1 << w;
        p   = 64'd1;
        d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (p < lim) begin
                p = p * 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/fib_bcd_adjust.sv
// Double-dabble correction: every BCD digit >= 5 gets +3, no carry between digits.
module fib_bcd_adjust
    import fib_pkg::*;
#(
    parameter int DIGITS = FIB_BCD_DIGITS
) (
    input  logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] adj
);

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = bcd[4*i +: 4];
        end
    end

endmodule

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per cycle) with valid/ready output.
// Optional wrap detector enabled by defining FIB_BCD_OVF_EN.
module fib_bcd_converter
    import fib_pkg::*;
#(
    parameter int IN_W   = FIB_IN_W,
    parameter int DIGITS = FIB_BCD_DIGITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*DIGITS-1:0]  out_bcd,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FIB_BCD_OVF_EN
    output logic                 ovf,
`endif
    output fib_bcd_state_t       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    localparam int CW = $clog2(IN_W + 1);
    localparam int BW = 4 * DIGITS;

    if (DIGITS < fib_bcd_digits(IN_W)) begin : g_digits_chk
        $error("DIGITS too small for IN_W");
    end

    fib_bcd_state_t  state;
    logic [IN_W-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   count;
    logic            unused_adj_msb;

    fib_bcd_adjust #(.DIGITS(DIGITS)) u_adjust (
        .bcd (bcd),
        .adj (bcd_adj)
    );

    // The digit count guarantees the top bit never carries a value out of the accumulator.
    assign unused_adj_msb = bcd_adj[BW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin   <= in_data;
                        bcd   <= '0;
                        count <= CW'(IN_W);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[BW-2:0], bin[IN_W-1]};
                    bin   <= {bin[IN_W-2:0], 1'b0};
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_bcd   = bcd;
    assign dbg_state = state;

`ifdef FIB_BCD_OVF_EN
    logic [IN_W-1:0] prev;

    // A smaller term than the previous accepted one means the sequence wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            ovf  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (in_data < prev)
                ovf <= 1'b1;
            prev <= in_data;
        end
    end
`endif

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Bench for fib_bcd_converter: directed vectors, expected BCD queued on accept and
// popped by a monitor on every output handshake.
module tb_fib_bcd_converter;
    import fib_pkg::*;

    localparam int IN_W   = FIB_IN_W;
    localparam int DIGITS = FIB_BCD_DIGITS;
    localparam int BW     = 4 * DIGITS;

    logic            clk;
    logic            rst;
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   out_bcd;
    logic            out_valid;
    logic            out_ready;
    fib_bcd_state_t  dbg_state;
`ifdef FIB_BCD_OVF_EN
    logic            ovf;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp;

    fib_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FIB_BCD_OVF_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: actual %0h required none", out_bcd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_bcd !== mon_exp) begin
                    errors++;
                    $display("FAIL out_bcd: actual %0h required %0h", out_bcd, mon_exp);
                end
            end
        end
    end

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic accept(input logic [IN_W-1:0] d, input logic [BW-1:0] e, input bit push);
        wait_ready();
        in_data  = d;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        check("state_shift", 64'(dbg_state), 64'(SHIFT));
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(n), 64'd32);
    endtask

    task automatic convert(input logic [IN_W-1:0] d, input logic [BW-1:0] e, input string name);
        accept(d, e, 1'b1);
        wait_out(name);
        @(posedge clk); #1;
        check("valid_pulse", 64'(out_valid), 64'd0);
        check("ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bcd", 64'(out_bcd), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef FIB_BCD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        convert(32'd13, 40'h0000000013, "lat_13");
        convert(32'hFFFF_FFFF, 40'h4294967295, "lat_max");
        convert(32'd0, 40'h0000000000, "lat_zero");

        // consumer stalls for five cycles
        out_ready = 1'b0;
        accept(32'd12345, 40'h0000012345, 1'b1);
        wait_out("lat_hold");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_bcd", 64'(out_bcd), 64'h0000012345);
            check("hold_state", 64'(dbg_state), 64'(DONE));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_ready", 64'(in_ready), 64'd1);

        // free-running generator: in_valid held high, data changes every cycle
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(40'h0000000007);
        exp_q.push_back(40'h0000034007);
        exp_q.push_back(40'h0000068007);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd7;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk); #1;
            in_data = IN_W'(k * 1000 + 7);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("gen_drain", 64'(exp_q.size()), 64'd0);
        check("gen_idle", 64'(in_ready), 64'd1);

        // reset mid-conversion aborts it
        accept(32'd777777, '0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_output", 64'(out_valid), 64'd0);
        convert(32'd89, 40'h0000000089, "lat_89");

`ifdef FIB_BCD_OVF_EN
        rst = 1'b1;
        @(posedge clk); #1;
        check("ovf_cleared", 64'(ovf), 64'd0);
        rst = 1'b0;
        convert(32'd2971215073, 40'h2971215073, "lat_ovf_a");
        check("ovf_before_wrap", 64'(ovf), 64'd0);
        convert(32'd512559680, 40'h0512559680, "lat_ovf_b");
        check("ovf_after_wrap", 64'(ovf), 64'd1);
        convert(32'd4000000000, 40'h4000000000, "lat_ovf_c");
        check("ovf_sticky", 64'(ovf), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ovf_rst", 64'(ovf), 64'd0);
        rst = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
